// File: rtl/uart_tx.sv
// 8N1 UART transmitter: pops one byte per frame from an upstream FIFO and
// shifts it out LSB first, holding every bit for ClksPerBit clock cycles.
module uart_tx #(
  parameter int ClksPerBit = 174
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       have_next_i,
  input  logic [7:0] data_i,
  output logic       next_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e          state_r;
  logic [CntW-1:0] cnt_r;
  logic [2:0]      idx_r;
  logic [7:0]      shift_r;
  logic            next_r;
  logic            tx_r;
  logic            busy_r;
  logic            bit_done_s;

  assign bit_done_s = (cnt_r == CntLast);

  // Frame sequencer; the pop strobe is a one-cycle pulse cleared on every other edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      next_r  <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      next_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // The byte is captured on the same edge that raises the pop strobe.
          if (have_next_i) begin
            shift_r <= data_i;
            next_r  <= 1'b1;
            tx_r    <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= START;
          end else begin
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        START: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            tx_r    <= shift_r[0];
            idx_r   <= 3'd0;
            state_r <= DATA;
          end else begin
            cnt_r   <= cnt_r + CntW'(1);
          end
        end
        DATA: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            shift_r <= {1'b0, shift_r[7:1]};
            idx_r   <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              tx_r    <= shift_r[1];
            end
          end else begin
            cnt_r   <= cnt_r + CntW'(1);
          end
        end
        STOP: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + CntW'(1);
          end
        end
        default: begin
          cnt_r   <= '0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign next_o = next_r;
  assign tx_o   = tx_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a FIFO model feeds the DUT, a monitor checks
// every frame against a waveform computed directly from the byte value.
module tb_uart_tx;

  localparam int C  = 4;
  localparam int C2 = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       have_next = 1'b0;
  logic [7:0] data = 8'h00;
  logic       nxt, tx, busy;
  logic       hn2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       nxt2, tx2, busy2;

  always #5 clk = ~clk;

  uart_tx #(.ClksPerBit(C)) dut (
    .clk_i(clk), .reset_i(rst_n), .have_next_i(have_next), .data_i(data),
    .next_o(nxt), .tx_o(tx), .busy_o(busy)
  );

  uart_tx #(.ClksPerBit(C2)) dut2 (
    .clk_i(clk), .reset_i(rst_n), .have_next_i(hn2), .data_i(d2),
    .next_o(nxt2), .tx_o(tx2), .busy_o(busy2)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_pushed = 0;
  int         n_pulses = 0;
  bit         in_frame = 1'b0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         starts_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Line level expected at cycle i of a frame: start bit, data LSB first, stop bit.
  function automatic logic exp_level(input logic [7:0] b, input int i, input int c);
    int k;
    k = i / c;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    n_pushed++;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || in_frame || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_within_budget", int'(t < 3000), 1);
  endtask

  // FIFO model: registered non-empty flag that stays high one cycle after the last pop.
  initial begin
    bit popped;
    forever begin
      @(negedge clk);
      popped = 1'b0;
      if (rst_n && nxt) begin
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        popped = 1'b1;
      end
      have_next = (fifo_q.size() != 0) || popped;
      data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Monitor: every pop strobe starts a frame checked cycle by cycle.
  initial begin
    logic [7:0] eb;
    logic [7:0] dec;
    int bad_wave, bad_busy, bad_next;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && nxt) begin
        n_pulses++;
        starts_q.push_back(cyc);
        in_frame = 1'b1;
        check("pop_has_expected_byte", int'(exp_q.size() > 0), 1);
        eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        dec = 8'h00;
        bad_wave = 0; bad_busy = 0; bad_next = 0; aborted = 1'b0;
        for (int i = 0; i < 10 * C; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== exp_level(eb, i, C)) bad_wave++;
          if (busy !== 1'b1) bad_busy++;
          if (nxt !== (i == 0)) bad_next++;
          if ((i % C) == (C / 2) && (i / C) >= 1 && (i / C) <= 8) dec[(i / C) - 1] = tx;
        end
        if (!aborted) begin
          check("frame_wave_bad_cycles", bad_wave, 0);
          check("frame_busy_bad_cycles", bad_busy, 0);
          check("frame_next_bad_cycles", bad_next, 0);
          check("frame_decoded_byte", dec, eb);
          @(negedge clk);
          if (rst_n) begin
            check("after_frame_tx_idle", tx, 1);
            check("after_frame_busy_low", busy, 0);
          end
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    int p0, bad, t, lows, highs, bcnt, npl;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_next", nxt, 0);
    check("reset_busy", busy, 0);
    check("reset_tx2", tx2, 1);
    check("reset_busy2", busy2, 0);
    rst_n = 1'b1;

    push(8'h55);
    wait_drain();

    starts_q.delete();
    push(8'hA3);
    push(8'h0F);
    wait_drain();
    check("b2b_frame_count", starts_q.size(), 2);
    if (starts_q.size() == 2) check("b2b_frame_period", starts_q[1] - starts_q[0], 10 * C + 1);
    check("b2b_fifo_empty", fifo_q.size(), 0);

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || nxt !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_1000_bad_cycles", bad, 0);

    p0 = n_pulses;
    push(8'($urandom_range(0, 255)));
    wait_drain();
    check("stale_flag_one_pulse", n_pulses - p0, 1);

    for (int r = 0; r < 6; r++) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_drain();

    p0 = n_pulses;
    push(8'hF0);
    t = 0;
    while (!nxt && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("f0_pop_seen", nxt, 1);
    repeat (4 * C + 1) @(negedge clk);
    check("f0_in_data_bit3", tx, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_tx_high", tx, 1);
    check("async_reset_busy_low", busy, 0);
    check("async_reset_next_low", nxt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_reset_line_idle", bad, 0);
    check("post_reset_no_repop", n_pulses - p0, 1);
    push(8'h81);
    wait_drain();
    check("total_pops_match_pushes", n_pulses, n_pushed);

    @(negedge clk);
    d2 = 8'h00;
    hn2 = 1'b1;
    @(negedge clk);
    hn2 = 1'b0;
    check("c2_pop_pulse", nxt2, 1);
    lows = 0; highs = 0; bcnt = 0; npl = 0;
    for (int i = 0; i < 10 * C2; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 18 && tx2 === 1'b0) lows++;
      if (i >= 18 && tx2 === 1'b1) highs++;
      if (busy2 === 1'b1) bcnt++;
      if (nxt2 === 1'b1) npl++;
    end
    check("c2_low_cycles", lows, 18);
    check("c2_high_cycles", highs, 2);
    check("c2_busy_cycles", bcnt, 20);
    check("c2_single_pulse", npl, 1);
    @(negedge clk);
    check("c2_idle_busy", busy2, 0);
    check("c2_idle_tx", tx2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that drains the byte FIFO and serialises each byte onto the TX line as an 8N1 frame. It sits directly downstream of the FIFO. It pops a byte when the FIFO reports data available and the line is idle, then shifts the byte out LSB first at a fixed clocks-per-bit rate.

## Interface
- `ClksPerBit`, default 174: clock cycles per UART bit (20 MHz / 115200). Must be ≥ 2.
- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `have_next_i`  in  1  FIFO non-empty flag. It is registered in the FIFO, so it may remain high for one cycle after the last pop.
- `data_i`  in  8  FIFO head byte. Valid while `have_next_i` is high; it changes the cycle after a pop takes effect.
- `next_o`  out  1  pop strobe to the FIFO. Single-cycle pulse, exactly one per transmitted byte.
- `tx_o`  out  1  serial line, idle high.
- `busy_o`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- FSM states and transitions:
  - IDLE: `tx_o`=1.
    - If `have_next_i`=1: latch `data_i` into the 8-bit shift register, set `next_o`<=1, `tx_o`<=0, clear the baud counter, and go to START.
    - Otherwise stay in IDLE.
  - START: hold `tx_o`=0 for `ClksPerBit` cycles.
    - Then `tx_o`<=shift[0], bit index<=0, and go to DATA.
  - DATA: hold each bit for `ClksPerBit` cycles.
    - At the end of each bit, shift right and increment the index.
    - After bit index 7 completes, `tx_o`<=1 and go to STOP.
  - STOP: hold `tx_o`=1 for `ClksPerBit` cycles, then go to IDLE.
- `next_o` is registered. It is high only in the first cycle of START and is cleared unconditionally in every other cycle.
- The byte is captured from `data_i` on the same edge that raises `next_o`, so the FIFO pointer advance never corrupts the captured byte.
- `have_next_i` is sampled only in IDLE. Its stale-high cycle after a pop falls inside START, so no double pop can occur.
- Baud counter: width $clog2(`ClksPerBit`). It counts 0..`ClksPerBit`-1 and wraps to 0 at each bit boundary.
- Bit index: 3 bits, range 0..7.
- `busy_o` is registered and equals (next state ≠ IDLE).
- All outputs are registered; there are no combinational paths from input to output.

## Timing
- Reset (asserted, asynchronous): `tx_o`=1, `next_o`=0, `busy_o`=0, state=IDLE, counters=0, shift register=0.
- Reset release: the first transition can occur on the first rising edge after `reset_i` goes high.
- Reset asserted mid-frame: `tx_o` goes high immediately. The popped byte is discarded and is not re-popped.
- Edge E, with IDLE and `have_next_i`=1:
  - From E+1: `next_o`=1 for exactly one cycle, `tx_o`=0, `busy_o`=1.
  - Start bit occupies cycles [E+1, E+`ClksPerBit`].
  - Data bit k occupies [E+1+(k+1)·`ClksPerBit`, E+(k+2)·`ClksPerBit`].
  - Stop bit ends at E+10·`ClksPerBit`.
  - IDLE resumes at E+10·`ClksPerBit`+1, with `busy_o`=0.
- Back-to-back bytes: IDLE lasts exactly one cycle between frames. Frame period = 10·`ClksPerBit`+1 cycles, and the line stays high during the gap.
- Empty FIFO: stay in IDLE indefinitely with `tx_o`=1 and `next_o`=0.
- `have_next_i` asserted while not in IDLE is ignored; it is re-sampled in IDLE.

## Test plan
- `ClksPerBit`=4, push 0x55, then hold `have_next_i`=1 for exactly one cycle via the FIFO:
  - One `next_o` pulse.
  - `tx_o` sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles.
  - `busy_o` high for 40 cycles.
- Push 0xA3 and 0x0F back to back:
  - Two frames separated by exactly 1 idle-high cycle.
  - Decoded bytes are 0xA3 then 0x0F.
  - Exactly two `next_o` pulses; the FIFO ends empty.
- Idle check: `have_next_i`=0 for 1000 cycles gives `tx_o`=1, `next_o`=0, `busy_o`=0 throughout.
- Stale-flag check: drive `have_next_i` high for 2 cycles (1 entry plus 1 stale cycle) gives exactly one `next_o` pulse and one frame.
- Reset mid-frame: assert `reset_i`=0 during data bit 3 of 0xF0.
  - `tx_o`=1 asynchronously, `busy_o`=0, no further pulses.
  - After release, a newly pushed 0x81 transmits correctly.
- Boundary check with `ClksPerBit`=2, byte 0x00: start plus 8 data bits give 18 low cycles, then 2 high cycles, then IDLE.
